// File: rtl/legv8_control_sequencer.sv
// rtl/legv8_control_sequencer.sv - LEGv8 multi-cycle control unit emitting the datapath ControlWord and immediate
module legv8_control_sequencer #(
    parameter int MEM_READ_CYCLES = 1,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic [31:0] IR,
    input  logic [3:0]  current_status,
    input  logic [3:0]  SR,
    output logic [39:0] ControlWord,
    output logic [63:0] constant,
    output logic [2:0]  state,
    output logic        halted,
    output logic        illegal
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_HALT  = 3'd7
    } state_t;

    localparam logic [4:0]  FS_AND = 5'b00000;
    localparam logic [4:0]  FS_ORR = 5'b00100;
    localparam logic [4:0]  FS_ADD = 5'b01000;
    localparam logic [4:0]  FS_SUB = 5'b01001;
    localparam logic [1:0]  WAIT_LAST = 2'(MEM_READ_CYCLES);
    localparam logic [39:0] CW_IDLE = {25'd0, 15'h7FFF};

    state_t     state_q, state_d;
    logic [1:0] wait_q, wait_d;
    logic       run_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            wait_q  <= 2'd0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            run_q   <= run;
        end
    end

    logic [4:0] rd, rn, rm;
    logic       is_add, is_sub, is_and, is_orr, is_subs, is_rrr;
    logic       is_addi, is_subi, is_ldur, is_stur, is_b, is_cbz, is_bcond;
    logic       cond_taken;

    assign rd = IR[4:0];
    assign rn = IR[9:5];
    assign rm = IR[20:16];

    assign is_add   = IR[31:21] == 11'b10001011000;
    assign is_sub   = IR[31:21] == 11'b11001011000;
    assign is_and   = IR[31:21] == 11'b10001010000;
    assign is_orr   = IR[31:21] == 11'b10101010000;
    assign is_subs  = IR[31:21] == 11'b11101011000;
    assign is_rrr   = is_add | is_sub | is_and | is_orr | is_subs;
    assign is_addi  = IR[31:22] == 10'b1001000100;
    assign is_subi  = IR[31:22] == 10'b1101000100;
    assign is_ldur  = IR[31:21] == 11'b11111000010;
    assign is_stur  = IR[31:21] == 11'b11111000000;
    assign is_b     = IR[31:26] == 6'b000101;
    assign is_cbz   = IR[31:24] == 8'b10110100;
    assign is_bcond = IR[31:24] == 8'b01010100;

    // SR is {V,C,N,Z}; only EQ/NE/LT/GE are decoded, other conditions fall through
    always_comb begin
        cond_taken = 1'b0;
        case (IR[4:0])
            5'h00:   cond_taken = SR[0];
            5'h01:   cond_taken = ~SR[0];
            5'h0A:   cond_taken = SR[1] == SR[3];
            5'h0B:   cond_taken = SR[1] != SR[3];
            default: cond_taken = 1'b0;
        endcase
    end

    logic [2:0] cgs;
    logic [1:0] ds, ps, size;
    logic [4:0] fs, da, sa, sb;
    logic       as_s, pcsel, bsel, il, sl, c0, mw, rw, ill;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        cgs = 3'd0;  as_s = 1'b0; ds = 2'b00; ps = 2'b00;
        pcsel = 1'b0; bsel = 1'b0; il = 1'b0; sl = 1'b0;
        fs = FS_AND; c0 = 1'b0; size = 2'b00; mw = 1'b0; rw = 1'b0;
        da = 5'd31; sa = 5'd31; sb = 5'd31;
        ill = 1'b0;
        case (state_q)
            S_IDLE: if (run) state_d = S_FETCH;
            S_FETCH: begin
                as_s = 1'b1; ds = 2'b11; il = 1'b1; size = 2'b10;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                ps = 2'b01;
                size = 2'b11;
                if (is_rrr) begin
                    da = rd; sa = rn; sb = rm; rw = 1'b1; sl = is_subs;
                    if (is_sub || is_subs) begin fs = FS_SUB; c0 = 1'b1; end
                    else if (is_add)       fs = FS_ADD;
                    else if (is_orr)       fs = FS_ORR;
                    else                   fs = FS_AND;
                end else if (is_addi || is_subi) begin
                    da = rd; sa = rn; bsel = 1'b1; cgs = 3'd1; rw = 1'b1;
                    fs = is_subi ? FS_SUB : FS_ADD;
                    c0 = is_subi;
                end else if (is_ldur || is_stur) begin
                    fs = FS_ADD; sa = rn; bsel = 1'b1; cgs = 3'd2;
                    ps = 2'b00;
                    wait_d = 2'd0;
                    state_d = S_MEM;
                end else if (is_b) begin
                    ps = 2'b10; cgs = 3'd3;
                end else if (is_cbz) begin
                    sa = rd; fs = FS_ORR;
                    if (current_status[0]) begin ps = 2'b10; cgs = 3'd4; end
                end else if (is_bcond) begin
                    if (cond_taken) begin ps = 2'b10; cgs = 3'd4; end
                end else begin
                    ill = 1'b1;
                    size = 2'b00;
                    if (HALT_ON_ILLEGAL) begin ps = 2'b00; state_d = S_HALT; end
                end
            end
            S_MEM: begin
                fs = FS_ADD; sa = rn; bsel = 1'b1; cgs = 3'd2; size = 2'b11;
                state_d = S_FETCH;
                if (is_stur) begin
                    sb = rd; ds = 2'b01; mw = 1'b1; ps = 2'b01;
                end else if (is_ldur) begin
                    ds = 2'b11;
                    if (wait_q == WAIT_LAST) begin
                        wait_d = 2'd0;
                        state_d = S_WB;
                    end else begin
                        wait_d = wait_q + 2'd1;
                        state_d = S_MEM;
                    end
                end
            end
            S_WB: begin
                fs = FS_ADD; sa = rn; bsel = 1'b1; cgs = 3'd2; size = 2'b11;
                ds = 2'b11; da = rd; rw = 1'b1; ps = 2'b01;
                state_d = S_FETCH;
            end
            S_HALT: if (run && !run_q) state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase
    end

    // Reset gates every output so an aborted MEM/WB never leaks MW/RW
    assign ControlWord = reset ? {cgs, state_d, as_s, ds, ps, pcsel, bsel, il, sl,
                                  fs, c0, size, mw, rw, da, sa, sb} : CW_IDLE;
    assign state   = state_q;
    assign halted  = reset & (state_q == S_HALT);
    assign illegal = reset & ill;

    always_comb begin
        case (ControlWord[39:37])
            3'd1:    constant = {52'd0, IR[21:10]};
            3'd2:    constant = {{55{IR[20]}}, IR[20:12]};
            3'd3:    constant = {{36{IR[25]}}, IR[25:0], 2'b00};
            3'd4:    constant = {{43{IR[23]}}, IR[23:5], 2'b00};
            default: constant = 64'd0;
        endcase
    end

    logic unused_flags;
    assign unused_flags = ^{current_status[3:1], SR[2]};

endmodule

// File: tb/tb_legv8_control_sequencer.sv
// tb/tb_legv8_control_sequencer.sv - directed self-checking bench for legv8_control_sequencer
module tb_legv8_control_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        run;
    logic [31:0] IR;
    logic [3:0]  current_status;
    logic [3:0]  SR;
    logic [39:0] ControlWord;
    logic [63:0] constant;
    logic [2:0]  state;
    logic        halted;
    logic        illegal;

    int checks = 0;
    int failures = 0;

    legv8_control_sequencer #(.MEM_READ_CYCLES(1), .HALT_ON_ILLEGAL(1'b1)) dut (
        .clock(clock), .reset(reset), .run(run), .IR(IR),
        .current_status(current_status), .SR(SR),
        .ControlWord(ControlWord), .constant(constant), .state(state),
        .halted(halted), .illegal(illegal)
    );

    always #5 clock = ~clock;

    localparam logic [31:0] I_ADD  = 32'h8B020023;
    localparam logic [31:0] I_ADDI = 32'h913FFCA5;
    localparam logic [31:0] I_LDUR = 32'hF85F8149;
    localparam logic [31:0] I_STUR = 32'hF81F8149;
    localparam logic [31:0] I_CBZ  = 32'hB4000040;
    localparam logic [31:0] I_BLT  = 32'h5400006B;
    localparam logic [31:0] I_B    = 32'h17FFFFFF;
    localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

    function automatic logic [39:0] mk_cw(
        input logic [2:0] cgs, input logic [2:0] ns, input logic as_s,
        input logic [1:0] ds, input logic [1:0] ps, input logic bsel,
        input logic il, input logic sl, input logic [4:0] fs, input logic c0,
        input logic [1:0] sz, input logic mw, input logic rw,
        input logic [4:0] da, input logic [4:0] sa, input logic [4:0] sb);
        return {cgs, ns, as_s, ds, ps, 1'b0, bsel, il, sl, fs, c0, sz, mw, rw, da, sa, sb};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    logic [39:0] cw_def, cw_fetch, cw_halt;

    initial begin
        cw_def   = mk_cw(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 5'd0, 0, 2'b00, 0, 0, 31, 31, 31);
        cw_fetch = mk_cw(0, 2, 1, 2'b11, 2'b00, 0, 1, 0, 5'd0, 0, 2'b10, 0, 0, 31, 31, 31);
        cw_halt  = mk_cw(0, 7, 0, 2'b00, 2'b00, 0, 0, 0, 5'd0, 0, 2'b00, 0, 0, 31, 31, 31);

        reset = 1'b0; run = 1'b0; IR = 32'd0; current_status = 4'd0; SR = 4'd0;
        tick(); tick();
        chk("reset_state", state, 3'd0);
        chk("reset_cw", ControlWord, cw_def);
        chk("reset_const", constant, 64'd0);
        chk("reset_halted", halted, 1'b0);
        chk("reset_illegal", illegal, 1'b0);

        reset = 1'b1;
        tick();
        chk("idle_state", state, 3'd0);
        chk("idle_cw", ControlWord, cw_def);

        run = 1'b1; IR = I_ADD;
        tick();
        chk("add_fetch_state", state, 3'd1);
        chk("add_fetch_cw", ControlWord, cw_fetch);
        tick();
        chk("add_exec_state", state, 3'd2);
        chk("add_exec_cw", ControlWord,
            mk_cw(0, 1, 0, 2'b00, 2'b01, 0, 0, 0, 5'b01000, 0, 2'b11, 0, 1, 3, 1, 2));
        tick();
        chk("add_back_fetch", state, 3'd1);

        IR = I_ADDI;
        tick();
        chk("addi_exec_cw", ControlWord,
            mk_cw(1, 1, 0, 2'b00, 2'b01, 1, 0, 0, 5'b01000, 0, 2'b11, 0, 1, 5, 5, 31));
        chk("addi_const", constant, 64'h0000000000000FFF);
        tick();

        IR = I_LDUR;
        tick();
        chk("ldur_exec_state", state, 3'd2);
        chk("ldur_const", constant, 64'hFFFFFFFFFFFFFFF8);
        chk("ldur_exec_cw", ControlWord,
            mk_cw(2, 3, 0, 2'b00, 2'b00, 1, 0, 0, 5'b01000, 0, 2'b11, 0, 0, 31, 10, 31));
        tick();
        chk("ldur_mem1_state", state, 3'd3);
        chk("ldur_mem1_cw", ControlWord,
            mk_cw(2, 3, 0, 2'b11, 2'b00, 1, 0, 0, 5'b01000, 0, 2'b11, 0, 0, 31, 10, 31));
        tick();
        chk("ldur_mem2_state", state, 3'd3);
        chk("ldur_mem2_cw", ControlWord,
            mk_cw(2, 4, 0, 2'b11, 2'b00, 1, 0, 0, 5'b01000, 0, 2'b11, 0, 0, 31, 10, 31));
        tick();
        chk("ldur_wb_state", state, 3'd4);
        chk("ldur_wb_cw", ControlWord,
            mk_cw(2, 1, 0, 2'b11, 2'b01, 1, 0, 0, 5'b01000, 0, 2'b11, 0, 1, 9, 10, 31));
        tick();
        chk("ldur_after_wb_state", state, 3'd1);
        chk("ldur_after_wb_rw", ControlWord[15], 1'b0);

        IR = I_STUR;
        tick();
        chk("stur_exec_ns", ControlWord[36:34], 3'd3);
        tick();
        chk("stur_mem_state", state, 3'd3);
        chk("stur_mem_cw", ControlWord,
            mk_cw(2, 1, 0, 2'b01, 2'b01, 1, 0, 0, 5'b01000, 0, 2'b11, 1, 0, 31, 10, 9));
        tick();
        chk("stur_after_state", state, 3'd1);
        chk("stur_after_mw", ControlWord[16], 1'b0);

        IR = I_CBZ; current_status = 4'b0001;
        tick();
        chk("cbz_taken_cw", ControlWord,
            mk_cw(4, 1, 0, 2'b00, 2'b10, 0, 0, 0, 5'b00100, 0, 2'b11, 0, 0, 31, 0, 31));
        chk("cbz_taken_const", constant, 64'd8);
        current_status = 4'b0000;
        #1;
        chk("cbz_nottaken_ps", ControlWord[30:29], 2'b01);
        chk("cbz_nottaken_const", constant, 64'd0);
        tick();

        IR = I_BLT; SR = 4'b0010;
        tick();
        chk("blt_taken_ps", ControlWord[30:29], 2'b10);
        chk("blt_taken_const", constant, 64'd12);
        SR = 4'b1010;
        #1;
        chk("blt_nottaken_ps", ControlWord[30:29], 2'b01);
        tick();

        IR = I_B;
        tick();
        chk("b_ps", ControlWord[30:29], 2'b10);
        chk("b_const", constant, 64'hFFFFFFFFFFFFFFFC);
        tick();

        IR = I_BAD;
        tick();
        chk("illegal_pulse", illegal, 1'b1);
        chk("illegal_exec_cw", ControlWord, cw_halt);
        tick();
        chk("halt_state", state, 3'd7);
        chk("halt_halted", halted, 1'b1);
        chk("halt_illegal_low", illegal, 1'b0);
        chk("halt_cw", ControlWord, cw_halt);
        tick();
        chk("halt_held_run_high", state, 3'd7);
        run = 1'b0;
        tick();
        chk("halt_held_run_low", state, 3'd7);
        run = 1'b1;
        tick();
        chk("halt_resume_fetch", state, 3'd1);
        chk("halt_resume_halted", halted, 1'b0);

        IR = I_STUR;
        tick();
        tick();
        chk("abort_mem_state", state, 3'd3);
        chk("abort_mem_mw", ControlWord[16], 1'b1);
        reset = 1'b0;
        #1;
        chk("abort_reset_cycle_cw", ControlWord, cw_def);
        tick();
        chk("abort_state", state, 3'd0);
        chk("abort_mw", ControlWord[16], 1'b0);
        chk("abort_cw", ControlWord, cw_def);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
